// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Mode encodings and the channel-count limit are used by the top, the channels and the bus interface.
package clkdiv_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int MAX_CHANNELS = 16;

    // Channel-select width never drops below one bit, even for a single channel.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Control/status bus of the multi-channel clock divider.
// The master drives enables, modes and divisor loads; the slave (the divider) returns clocks and ticks.
interface multi_clock_divider_if
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 23
);

    localparam int SEL_W = sel_width(CHANNELS);

    logic [CHANNELS-1:0]  enable;
    logic [CHANNELS-1:0]  mode;
    logic                 sync;
    logic                 load;
    logic [SEL_W-1:0]     load_sel;
    logic [CNT_WIDTH-1:0] load_div;
    logic [CHANNELS-1:0]  clock_out;
    logic [CHANNELS-1:0]  tick;

    modport master (
        output enable, mode, sync, load, load_sel, load_div,
        input  clock_out, tick
    );

    modport slave (
        input  enable, mode, sync, load, load_sel, load_div,
        output clock_out, tick
    );

endinterface

// File: rtl/clock_div_channel.sv
// One divider channel: counter, shadowed divisor and toggle/pulse output stage.
// A new divisor waits in div_pending until a terminal edge, a sync, or an idle (disabled) edge.
module clock_div_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_WIDTH   = 23,
    parameter int DEFAULT_DIV = 2500000
)(
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 sync,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_div,
    output logic                 clock_out,
    output logic                 tick
);

    localparam logic [CNT_WIDTH-1:0] RESET_DIV = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] div_active;
    logic [CNT_WIDTH-1:0] div_pending;
    logic [CNT_WIDTH-1:0] eff_div;
    logic                 pend_valid;
    logic                 terminal;

    // A programmed divisor of zero behaves as one.
    always_comb begin
        eff_div  = (div_active == '0) ? ONE : div_active;
        terminal = enable && (cnt == eff_div - ONE);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            tick      <= 1'b0;
            clock_out <= 1'b0;
        end else if (sync) begin
            cnt       <= '0;
            tick      <= 1'b0;
            clock_out <= 1'b0;
        end else if (enable) begin
            cnt  <= terminal ? '0 : cnt + ONE;
            tick <= terminal;
            if (mode == MODE_TOGGLE) begin
                clock_out <= clock_out ^ terminal;
            end else begin
                clock_out <= terminal;
            end
        end else begin
            tick <= 1'b0;
            if (mode == MODE_PULSE) begin
                clock_out <= 1'b0;
            end
        end
    end

    // A load in the same edge as an application is kept as the next pending value.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            div_active  <= RESET_DIV;
            div_pending <= RESET_DIV;
            pend_valid  <= 1'b0;
        end else begin
            if (pend_valid && (sync || terminal || !enable)) begin
                div_active <= div_pending;
                pend_valid <= 1'b0;
            end
            if (load) begin
                div_pending <= load_div;
                pend_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel clock divider: CHANNELS independent dividers sharing one load port and one sync.
// Loads addressed past the last channel match no strobe and are dropped.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 23,
    parameter int DEFAULT_DIV = 2500000
)(
    input  logic                  clock_in,
    input  logic                  reset_n,
    multi_clock_divider_if.slave  bus
);

    logic [CHANNELS-1:0] load_hit;
    logic [CHANNELS-1:0] clock_vec;
    logic [CHANNELS-1:0] tick_vec;

    always_comb begin
        load_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            load_hit[i] = bus.load && (int'(bus.load_sel) == i);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        clock_div_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clock_in  (clock_in),
            .reset_n   (reset_n),
            .enable    (bus.enable[g]),
            .mode      (bus.mode[g]),
            .sync      (bus.sync),
            .load      (load_hit[g]),
            .load_div  (bus.load_div),
            .clock_out (clock_vec[g]),
            .tick      (tick_vec[g])
        );
    end

    assign bus.clock_out = clock_vec;
    assign bus.tick      = tick_vec;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: a per-cycle behavioural model plus directed literal checks.
// Three channels are used so that load_sel can address a channel that does not exist.
module tb_multi_clock_divider;
    import clkdiv_pkg::*;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int DDIV = 4;
    localparam int SW   = sel_width(NCH);

    logic clock_in = 1'b0;
    logic reset_n;
    int   vectors;
    int   miscompares;

    multi_clock_divider_if #(.CHANNELS(NCH), .CNT_WIDTH(CW)) bus ();

    multi_clock_divider #(
        .CHANNELS    (NCH),
        .CNT_WIDTH   (CW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clock_in = ~clock_in;

    task automatic checkOutput(input string name, input logic [NCH-1:0] actual, input logic [NCH-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] en, input logic [NCH-1:0] md, input logic sy,
                                 input logic ld, input logic [SW-1:0] sel, input logic [CW-1:0] dv);
        @(negedge clock_in);
        bus.enable   = en;
        bus.mode     = md;
        bus.sync     = sy;
        bus.load     = ld;
        bus.load_sel = sel;
        bus.load_div = dv;
    endtask

    // Model: each channel tracks its position in the current period and the period it runs at.
    int             m_pos  [NCH];
    int             m_per  [NCH];
    int             m_next [NCH];
    bit             m_has_next [NCH];
    logic [NCH-1:0] m_out;
    logic [NCH-1:0] m_tick;

    always @(posedge clock_in or negedge reset_n) begin
        int  period;
        bit  at_end;
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_pos[i]      = 0;
                m_per[i]      = DDIV;
                m_next[i]     = DDIV;
                m_has_next[i] = 0;
            end
            m_out  = '0;
            m_tick = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                period = (m_per[i] < 1) ? 1 : m_per[i];
                at_end = bus.enable[i] && (m_pos[i] == period - 1);
                if (bus.sync) begin
                    m_pos[i]  = 0;
                    m_out[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                    if (m_has_next[i]) begin
                        m_per[i] = m_next[i];
                        m_has_next[i] = 0;
                    end
                end else if (bus.enable[i]) begin
                    m_pos[i]  = at_end ? 0 : m_pos[i] + 1;
                    m_tick[i] = at_end;
                    m_out[i]  = bus.mode[i] ? at_end : (m_out[i] ^ at_end);
                    if (at_end && m_has_next[i]) begin
                        m_per[i] = m_next[i];
                        m_has_next[i] = 0;
                    end
                end else begin
                    m_tick[i] = 1'b0;
                    if (bus.mode[i]) m_out[i] = 1'b0;
                    if (m_has_next[i]) begin
                        m_per[i] = m_next[i];
                        m_has_next[i] = 0;
                    end
                end
                if (bus.load && int'(bus.load_sel) == i) begin
                    m_next[i] = int'(bus.load_div);
                    m_has_next[i] = 1;
                end
            end
        end
    end

    always @(posedge clock_in) begin
        #2;
        checkOutput("model_clock_out", bus.clock_out, m_out);
        checkOutput("model_tick", bus.tick, m_tick);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not finish, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NCH-1:0] exp_clk;
        logic [NCH-1:0] exp_tick;
        logic [NCH-1:0] en;
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        bus.enable   = '1;
        bus.mode     = '0;
        bus.sync     = 1'b0;
        bus.load     = 1'b0;
        bus.load_sel = '0;
        bus.load_div = '0;
        repeat (2) @(posedge clock_in);
        #2;
        checkOutput("reset_clock_out", bus.clock_out, '0);
        checkOutput("reset_tick", bus.tick, '0);
        @(negedge clock_in);
        reset_n = 1'b1;

        // All channels toggle at the default divisor of 4.
        for (int e = 1; e <= 12; e++) begin
            @(posedge clock_in);
            #2;
            exp_clk  = ((e / 4) % 2 == 1) ? '1 : '0;
            exp_tick = (e % 4 == 0) ? '1 : '0;
            checkOutput("t1_clock_out", bus.clock_out, exp_clk);
            checkOutput("t1_tick", bus.tick, exp_tick);
        end

        // ch0 toggle div 5, ch1 pulse div 3, aligned by a sync.
        applyStimulus('1, '0, 1'b0, 1'b1, 2'd0, 8'd5);
        applyStimulus('1, '0, 1'b0, 1'b1, 2'd1, 8'd3);
        applyStimulus(3'b011, 3'b010, 1'b1, 1'b0, 2'd0, 8'd0);
        @(posedge clock_in);
        #2;
        checkOutput("t2_sync_clock_out", bus.clock_out, '0);
        for (int k = 1; k <= 22; k++) begin
            applyStimulus(3'b011, 3'b010, 1'b0, (k == 12), 2'd0, 8'd2);
            @(posedge clock_in);
            #2;
            exp_clk[2]  = 1'b0;
            exp_clk[1]  = (k % 3 == 0);
            exp_tick[2] = 1'b0;
            exp_tick[1] = (k % 3 == 0);
            if (k <= 14) begin
                exp_clk[0]  = ((k / 5) % 2 == 1);
                exp_tick[0] = (k % 5 == 0);
            end else begin
                exp_clk[0]  = (((k - 15) / 2) % 2 == 0);
                exp_tick[0] = ((k - 15) % 2 == 0);
            end
            checkOutput("t2_clock_out", bus.clock_out, exp_clk);
            checkOutput("t2_tick", bus.tick, exp_tick);
        end

        // ch0 gets divisor 0; a load to a missing channel rides along with the sync.
        applyStimulus(3'b011, 3'b010, 1'b0, 1'b1, 2'd0, 8'd0);
        applyStimulus(3'b011, 3'b010, 1'b1, 1'b1, 2'd3, 8'd7);
        @(posedge clock_in);
        #2;
        checkOutput("t4_sync_clock_out", bus.clock_out, '0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(3'b011, 3'b010, 1'b0, 1'b0, 2'd0, 8'd0);
            @(posedge clock_in);
            #2;
            exp_clk  = {1'b0, (k % 3 == 0), (k % 2 == 1)};
            exp_tick = {1'b0, (k % 3 == 0), 1'b1};
            checkOutput("t4_clock_out", bus.clock_out, exp_clk);
            checkOutput("t4_tick", bus.tick, exp_tick);
        end

        // Pending div 4 on ch1 taken by sync; ch2 paused mid-period for 10 edges.
        applyStimulus(3'b011, 3'b010, 1'b0, 1'b1, 2'd1, 8'd4);
        applyStimulus(3'b111, 3'b010, 1'b1, 1'b0, 2'd0, 8'd0);
        @(posedge clock_in);
        #2;
        checkOutput("t5_sync_clock_out", bus.clock_out, '0);
        checkOutput("t5_sync_tick", bus.tick, '0);
        for (int k = 1; k <= 18; k++) begin
            en = (k >= 7 && k <= 16) ? 3'b011 : 3'b111;
            applyStimulus(en, 3'b010, 1'b0, 1'b0, 2'd0, 8'd0);
            @(posedge clock_in);
            #2;
            exp_clk  = {(k >= 4 && k < 18), (k % 4 == 0), (k % 2 == 1)};
            exp_tick = {(k == 4 || k == 18), (k % 4 == 0), 1'b1};
            checkOutput("t6_clock_out", bus.clock_out, exp_clk);
            checkOutput("t6_tick", bus.tick, exp_tick);
        end

        // Asynchronous reset between clock edges, then restart at the default divisor.
        @(posedge clock_in);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_clock_out", bus.clock_out, '0);
        checkOutput("async_reset_tick", bus.tick, '0);
        bus.enable = '1;
        bus.mode   = '0;
        @(negedge clock_in);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock_in);
            #2;
            exp_clk = ((e / 4) % 2 == 1) ? '1 : '0;
            checkOutput("post_reset_clock_out", bus.clock_out, exp_clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised, multi-channel successor to the single fixed divider. It derives up to CHANNELS independent slow clocks/ticks from `clock_in`. Each channel has a divisor that can be reloaded at runtime without glitches, a per-channel enable, and a selectable toggle (50% duty) or pulse output mode. It sits between the board oscillator and the display/debounce/timer logic, and replaces per-consumer hard-coded dividers.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16).
- CNT_WIDTH, 23: width of each channel's counter and divisor.
- DEFAULT_DIV, 2500000: divisor loaded into every channel at reset. Must be less than 2^CNT_WIDTH.
- clock_in  input  1: system clock; all logic is on the rising edge.
- reset_n  input  1: asynchronous, active-low reset.
- enable  input  CHANNELS: per-channel count enable.
- mode  input  CHANNELS: per channel, 0 = toggle, 1 = pulse.
- sync  input  1: synchronous restart of all channels.
- load  input  1: one-cycle divisor write strobe.
- load_sel  input  $clog2(CHANNELS) (min 1): target channel for `load`.
- load_div  input  CNT_WIDTH: new divisor value.
- clock_out  output  CHANNELS: divided clock/pulse per channel.
- tick  output  CHANNELS: one-cycle strobe at each terminal count.

## Operation
- Each channel has these registers:
  - `cnt` [CNT_WIDTH]
  - `div_active` [CNT_WIDTH]
  - `div_pending` [CNT_WIDTH]
  - `pend_valid`
  - `clock_out`
  - `tick`
- Effective divisor: D = max(div_active, 1). A value of 0 is treated as 1.
- Terminal condition: enable[i] && cnt == D-1.
- On a terminal edge: cnt <= 0 and tick <= 1. On every other enabled edge: cnt <= cnt+1 and tick <= 0.
- Toggle mode: clock_out toggles on each terminal edge. Period is 2·D cycles, 50% duty.
- Pulse mode: clock_out <= terminal condition. High for 1 cycle every D cycles, identical to tick.
- Enable low: cnt and toggle-mode clock_out hold. tick <= 0. Pulse-mode clock_out <= 0.
- Mode change takes effect on the next edge. Switching into pulse mode drives clock_out low unless that edge is terminal. The counter is not disturbed.
- Load: when load=1 and load_sel<CHANNELS, set div_pending <= load_div and pend_valid <= 1. A load with load_sel ≥ CHANNELS is ignored.
- Pending divisor application:
  - Applied at the channel's next terminal edge: div_active <= div_pending, pend_valid <= 0. The current period completes with the old divisor.
  - If the channel is disabled, it is applied on the first edge where pend_valid=1 and enable[i]=0.
  - A load on the same edge as a terminal does not affect that terminal. It applies at the following one.
  - A second load before application overwrites div_pending; the last write wins.
- sync=1, applied to all channels:
  - cnt <= 0, clock_out <= 0, tick <= 0.
  - Any pending divisor is applied immediately.
  - Priority: sync > terminal > count.
  - load on the same edge as sync is captured as pending and is not applied by that sync.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Reset (asynchronous, reset_n=0):
  - cnt=0, clock_out=0, tick=0
  - div_active=DEFAULT_DIV, div_pending=DEFAULT_DIV, pend_valid=0
- Toggle mode, D, enabled continuously from reset release: the first clock_out rise follows the D-th rising edge. Thereafter it toggles every D edges.
- Pulse mode: tick/clock_out are high during the cycle following the D-th enabled edge, then every D edges.
- D=1: toggle mode gives clock_in/2. Pulse mode holds clock_out high continuously while enabled.
- Reset asserted mid-period: immediate clear. Counting restarts from 0 with DEFAULT_DIV. Any pending load is discarded.
- Latency from load strobe to the new period starting: at most the remainder of the current period + 1 cycle.

## Structure
- Package `clkdiv_pkg`:
  - MODE_TOGGLE=1'b0, MODE_PULSE=1'b1.
  - Max-channel limit constant.
- Sub-module `clock_div_channel`: one channel (counter, divisor shadow, mode/enable logic). It has ports for per-channel load strobe, load value and sync.
- The top level:
  - instantiates CHANNELS copies via generate;
  - decodes load_sel into a one-hot per-channel load strobe.

## Test plan
- Reset, then toggle mode, DEFAULT_DIV overridden to 4, enable=all → clock_out[i] rises at edge 4 and falls at edge 8. Period 8. tick pulses at edges 4, 8, 12.
- Channel 1 in pulse mode with div 3, channel 0 toggle with div 5, simultaneously → ch1 1-cycle pulse every 3 cycles, ch0 period 10. The channels are independent.
- Load div=2 into ch0 at cnt=1 of a D=5 period → remaining old period completes (terminal at cnt=4). Subsequent toggles every 2 cycles.
- Load div=0 → treated as D=1. Toggle output is clock_in/2. Load with load_sel=CHANNELS → no change on any channel.
- sync asserted mid-count while a pending load is outstanding → all clock_out=0 and cnt=0 next cycle. Pending divisor active immediately. Channels phase-aligned afterwards.
- Disable ch2 mid-period at cnt=2, hold 10 cycles, re-enable → toggle output held, count resumes from 2. reset_n pulsed mid-period → all outputs 0 asynchronously.
